mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the single 16x4 data memory between the CPU control unit (port 0) and a debug/loader host (port 1). Sits between the `cpu` memory interface and the data memory, replacing the direct `mem_clk`/`mem_we`/`mem_addr`/`mem_data`/`mem_out` connection. Serialises accesses through a fixed four-state sequence and grants round-robin when both ports request together.

## Interface
- `RESET_PRIO`, default 0: port that wins the first simultaneous request after reset (0 or 1).
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `r0_req`  in  1  port 0 (CPU) access request.
- `r0_we`  in  1  port 0 write enable (1 = write, 0 = read).
- `r0_addr`  in  4  port 0 memory address.
- `r0_wdata`  in  4  port 0 write data.
- `r0_ack`  out  1  port 0 transaction complete, one-cycle pulse.
- `r0_rdata`  out  4  port 0 read data, valid while `r0_ack`=1.
- `r1_req`, `r1_we`, `r1_addr`, `r1_wdata`, `r1_ack`, `r1_rdata`: same as port 0, for the debug host.
- `mem_clk`  out  1  memory strobe; memory acts on its rising edge.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  4  memory address.
- `mem_data`  out  4  memory write data.
- `mem_out`  in  4  memory read data.
- `busy`  out  1  transaction in progress (state != IDLE).
- `owner`  out  1  port of current or last granted transaction.

## Operation
- FSM states: IDLE, SETUP, STROBE, ACK.
- IDLE: if neither req, stay. If one req, grant it. If both, grant the port named by priority pointer `prio`. On grant, latch we/addr/wdata into internal registers, set `owner` to granted port, go to SETUP.
- SETUP: drive `mem_addr`/`mem_data`/`mem_we` from latched values, `mem_clk`=0. Go to STROBE.
- STROBE: `mem_clk`=1; address, data and we held. Capture `mem_out` into the granted port's rdata register at end of cycle. Go to ACK.
- ACK: `mem_clk`=0, `mem_we`=0; assert granted port's ack for exactly this cycle. `prio` is set to the non-granted port. Go to IDLE.
- Write transactions also update rdata with `mem_out` from STROBE (read-after-write value). Requesters ignore it on writes.
- `mem_addr`/`mem_data` hold their last values in ACK and IDLE until the next SETUP.
- Each port's rdata holds its last value until that port's next ACK. The other port's rdata and ack are untouched.
- `prio` updates only on a contested or uncontested grant, never while idle.
- Addresses are 4 bits, full 0..15 range, no wrap logic. Address 15 is an ordinary address.

## Timing
- Reset values: state IDLE, `prio`=RESET_PRIO, `owner`=RESET_PRIO, `mem_clk`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `r0_ack`=`r1_ack`=0, `r0_rdata`=`r1_rdata`=0, `busy`=0.
- Latency: req sampled high in IDLE at cycle N. SETUP at N+1, STROBE at N+2, ack at N+3. Next grant earliest at IDLE N+4, i.e. one access per 4 cycles.
- Handshake:
  - Requester holds req, we, addr and wdata stable from assertion through its ack cycle.
  - Requester drops req in the cycle after ack unless it wants another access.
  - A req still high in the IDLE cycle after ack is a new request.
- A non-granted port keeps req high and waits. It is granted at the next IDLE and cannot be starved by the other port.
- Simultaneous events: both ports requesting in IDLE gives one grant only, per `prio`. Requests arriving during SETUP/STROBE/ACK are sampled only at the next IDLE.
- Reset mid-operation takes priority over every state:
  - Next cycle is IDLE with all reset values, and no ack is issued for the aborted transaction.
  - A write aborted after STROBE may already be committed to memory. A write aborted before STROBE is not.

## Test plan
- Port 0 read, addr 5, memory holds 0xA -> `mem_clk` high at N+2 only, `r0_ack`=1 at N+3 with `r0_rdata`=0xA, `r1_ack` stays 0.
- Port 1 write addr 15, data 0x3, then port 1 read addr 15 -> second ack returns 0x3; `mem_we`=1 in SETUP/STROBE of first transaction only.
- Both ports request continuously from reset (RESET_PRIO=0) -> grants 0,1,0,1 with acks every 4 cycles. Each port reads back its own address's data.
- Port 0 requests continuously, port 1 requests once mid-stream -> port 1 granted at the next IDLE after the current port 0 ack, then port 0 resumes.
- Reset asserted during STROBE of a port 1 read -> next cycle `mem_clk`=0, `busy`=0, no `r1_ack`, `prio`=RESET_PRIO. A following port 1 request completes normally.
- Write addr 0 data 0xF, reset asserted in SETUP -> memory addr 0 unchanged on readback.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of the shared 16x4 data memory.
// Port 0 is the CPU control unit, port 1 the debug/loader host. Every access
// runs through IDLE -> SETUP -> STROBE -> ACK, so one access completes every
// four cycles. Simultaneous requests are granted round-robin.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   rN_req/we/addr/wdata request side of port N (held stable until rN_ack)
//   rN_ack               one-cycle completion pulse for port N
//   rN_rdata             port N read data, valid while rN_ack is high
//   mem_clk/we/addr/data memory strobe and write side
//   mem_out              memory read data
//   busy                 a transaction is in progress
//   owner                port of the current or last granted transaction
module mem_arbiter #(
   parameter bit RESET_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       r0_req,
   input  logic       r0_we,
   input  logic [3:0] r0_addr,
   input  logic [3:0] r0_wdata,
   output logic       r0_ack,
   output logic [3:0] r0_rdata,
   input  logic       r1_req,
   input  logic       r1_we,
   input  logic [3:0] r1_addr,
   input  logic [3:0] r1_wdata,
   output logic       r1_ack,
   output logic [3:0] r1_rdata,
   output logic       mem_clk,
   output logic       mem_we,
   output logic [3:0] mem_addr,
   output logic [3:0] mem_data,
   input  logic [3:0] mem_out,
   output logic       busy,
   output logic       owner
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSetup  = 2'd1;
   localparam logic [1:0] StStrobe = 2'd2;
   localparam logic [1:0] StAck    = 2'd3;

   logic [1:0] state_q, state_d;
   logic       prio_q, prio_d;
   logic       owner_q, owner_d;
   logic       we_q, we_d;
   logic [3:0] addr_q, addr_d;
   logic [3:0] data_q, data_d;
   logic [3:0] rdata0_q, rdata0_d;
   logic [3:0] rdata1_q, rdata1_d;
   logic       grant;

   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      data_d   = data_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      grant    = 1'b0;
      case (state_q)
         StIdle: begin
            if (r0_req || r1_req) begin
               // Contested requests follow prio; otherwise the lone requester wins.
               grant   = (r0_req && r1_req) ? prio_q : r1_req;
               owner_d = grant;
               we_d    = grant ? r1_we    : r0_we;
               addr_d  = grant ? r1_addr  : r0_addr;
               data_d  = grant ? r1_wdata : r0_wdata;
               state_d = StSetup;
            end
         end
         StSetup: begin
            state_d = StStrobe;
         end
         StStrobe: begin
            // Writes capture too: mem_out then shows the value just written.
            if (owner_q) begin
               rdata1_d = mem_out;
            end else begin
               rdata0_d = mem_out;
            end
            state_d = StAck;
         end
         default: begin
            prio_d  = ~owner_q;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         prio_q   <= RESET_PRIO;
         owner_q  <= RESET_PRIO;
         we_q     <= 1'b0;
         addr_q   <= 4'd0;
         data_q   <= 4'd0;
         rdata0_q <= 4'd0;
         rdata1_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Address and data come straight from the latched request, so they change
   // at SETUP and hold through ACK and IDLE until the next grant.
   assign mem_addr = addr_q;
   assign mem_data = data_q;
   assign mem_clk  = (state_q == StStrobe);
   assign mem_we   = we_q && ((state_q == StSetup) || (state_q == StStrobe));
   assign r0_ack   = (state_q == StAck) && !owner_q;
   assign r1_ack   = (state_q == StAck) && owner_q;
   assign r0_rdata = rdata0_q;
   assign r1_rdata = rdata1_q;
   assign busy     = (state_q != StIdle);
   assign owner    = owner_q;

endmodule
